snake_engine: RTL

//  Parametrised snake game core on a cell grid. It holds the body as a shift array with the head at index 0.
//  - Steps the snake once per accepted move tick.
//  - Applies direction requests, rejecting 180-degree reversals.
//  - Grows the body after an apple is eaten.
//  - Detects wall and self collisions.
//  - Answers cell-occupancy queries for the pixel renderer.

---
 rtl/snake_engine.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/snake_engine.sv
// Snake game core: the body is a shift array with the head at index 0. The engine steps on move
// ticks, filters direction requests, grows after apples, detects collisions and answers renderer queries.
module snake_engine #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int XW       = 6,
  parameter int YW       = 5,
  parameter int MAX_LEN  = 64,
  parameter int LW       = 7,
  parameter int INIT_LEN = 3,
  parameter int GROW     = 3,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          tick,
  input  logic [3:0]    dir_req,
  input  logic [XW-1:0] apple_x,
  input  logic [YW-1:0] apple_y,
  input  logic [XW-1:0] query_x,
  input  logic [YW-1:0] query_y,
  output logic          query_head,
  output logic          query_body,
  output logic          apple_eaten,
  output logic [LW-1:0] length,
  output logic          playing,
  output logic          game_over
);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_STEP, S_CHECK, S_OVER} state_e;

  // Direction encoding is one-hot {right, down, left, up}.
  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0001;

  state_e        state_q, state_d;
  logic [3:0]    cur_dir_q, cur_dir_d;
  logic [3:0]    nxt_dir_q, nxt_dir_d;
  logic [LW-1:0] length_q, length_d;
  logic [LW-1:0] pending_q, pending_d;
  logic          query_head_q, query_head_d;
  logic          query_body_q, query_body_d;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];

  logic          req_onehot;
  logic          req_ok;
  logic [XW-1:0] new_x;
  logic [YW-1:0] new_y;
  logic          hit_wall;
  logic          self_hit;
  logic          apple_hit;
  logic [LW:0]   pending_sum;

  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[1], d[0], d[3], d[2]};
  endfunction

  assign req_onehot  = (dir_req != 4'b0) && ((dir_req & (dir_req - 4'd1)) == 4'b0);
  assign req_ok      = req_onehot && (dir_req != opposite(cur_dir_q));
  assign apple_hit   = (seg_x_q[0] == apple_x) && (seg_y_q[0] == apple_y);
  assign pending_sum = {1'b0, pending_q} + (LW+1)'(GROW);

  // Wall test uses the current head so an exit is caught before the coordinate wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    new_x    = seg_x_q[0];
    new_y    = seg_y_q[0];
    hit_wall = 1'b0;
    case (nxt_dir_q)
      DIR_RIGHT: begin hit_wall = (seg_x_q[0] == XW'(GRID_W - 1)); new_x = seg_x_q[0] + XW'(1); end
      DIR_DOWN:  begin hit_wall = (seg_y_q[0] == YW'(GRID_H - 1)); new_y = seg_y_q[0] + YW'(1); end
      DIR_LEFT:  begin hit_wall = (seg_x_q[0] == '0);              new_x = seg_x_q[0] - XW'(1); end
      DIR_UP:    begin hit_wall = (seg_y_q[0] == '0);              new_y = seg_y_q[0] - YW'(1); end
      default:   hit_wall = 1'b0;
    endcase
  end

  always_comb begin
    self_hit     = 1'b0;
    query_body_d = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LW'(i) < length_q) begin
        if (seg_x_q[i] == seg_x_q[0] && seg_y_q[i] == seg_y_q[0]) self_hit = 1'b1;
        if (seg_x_q[i] == query_x && seg_y_q[i] == query_y) query_body_d = 1'b1;
      end
    end
    query_head_d = (length_q != '0) && (seg_x_q[0] == query_x) && (seg_y_q[0] == query_y);
    if (state_q == S_IDLE) begin
      query_body_d = 1'b0;
      query_head_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    nxt_dir_d = nxt_dir_q;
    length_d  = length_q;
    pending_d = pending_q;
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d   = S_PLAY;
          cur_dir_d = DIR_RIGHT;
          nxt_dir_d = DIR_RIGHT;
          length_d  = LW'(INIT_LEN);
          pending_d = '0;
          for (int i = 0; i < INIT_LEN; i++) begin
            seg_x_d[i] = XW'(START_X - i);
            seg_y_d[i] = YW'(START_Y);
          end
        end
      end
      S_PLAY: begin
        if (req_ok) nxt_dir_d = dir_req;
        if (tick) state_d = S_STEP;
      end
      S_STEP: begin
        cur_dir_d = nxt_dir_q;
        if (hit_wall) begin
          state_d = S_OVER;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = new_x;
          seg_y_d[0] = new_y;
          // Growing keeps the old tail: the shifted-in copy becomes the new last segment.
          if (pending_q != '0 && length_q < LW'(MAX_LEN)) begin
            length_d  = length_q + LW'(1);
            pending_d = pending_q - LW'(1);
          end
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (self_hit) begin
          state_d = S_OVER;
        end else begin
          if (apple_hit)
            pending_d = (pending_sum > (LW+1)'(MAX_LEN)) ? LW'(MAX_LEN) : pending_sum[LW-1:0];
          state_d = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      cur_dir_q    <= DIR_RIGHT;
      nxt_dir_q    <= DIR_RIGHT;
      length_q     <= '0;
      pending_q    <= '0;
      query_head_q <= 1'b0;
      query_body_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_dir_q    <= cur_dir_d;
      nxt_dir_q    <= nxt_dir_d;
      length_q     <= length_d;
      pending_q    <= pending_d;
      query_head_q <= query_head_d;
      query_body_q <= query_body_d;
    end
  end

  // NOTE: the body array has no reset; every reader is gated by length, which is reset to zero.
  always_ff @(posedge clk) begin
    seg_x_q <= seg_x_d;
    seg_y_q <= seg_y_d;
  end

  assign apple_eaten = (state_q == S_CHECK) && apple_hit && !self_hit;
  assign query_head  = query_head_q;
  assign query_body  = query_body_q;
  assign length      = length_q;
  assign playing     = (state_q == S_PLAY) || (state_q == S_STEP) || (state_q == S_CHECK);
  assign game_over   = (state_q == S_OVER);

endmodule
